// File: rtl/fitbit_pkg.sv
// Shared types, default constants and helpers for the activity tracker core.
package fitbit_pkg;

    localparam int DEF_TICK_CYCLES = 100_000_000;
    localparam int DEF_STEP_W      = 14;
    localparam int DEF_STEP_SAT    = 9999;
    localparam int DEF_OVER_RATE   = 32;
    localparam int DEF_OVER_SECS   = 9;
    localparam int DEF_HI_RATE     = 64;
    localparam int DEF_HI_MIN      = 60;

    localparam int RATE_W = 8;   // steps-per-second counter width
    localparam int RUN_W  = 8;   // high-activity run length width
    localparam int HI_W   = 16;  // accumulated high-activity seconds width
    localparam int OVER_W = 4;   // early-burst count / elapsed window width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_ACTIVE = 2'd2
    } hi_state_t;

    // Saturating add for the high-activity accumulator.
    function automatic logic [HI_W-1:0] sat_add_hi(input logic [HI_W-1:0] a,
                                                   input logic [HI_W-1:0] b);
        logic [HI_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[HI_W] ? {HI_W{1'b1}} : s[HI_W-1:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second divider: TICK pulses for one cycle every TICK_CYCLES cycles,
// first pulse TICK_CYCLES cycles after reset release or CLR.
module tick_gen
    import fitbit_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    output logic TICK
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running modulo counter with registered terminal-count pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt  <= '0;
            TICK <= 1'b0;
        end else if (CLR) begin
            cnt  <= '0;
            TICK <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            TICK <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            TICK <= 1'b0;
        end
    end

endmodule

// File: rtl/fitbit_core.sv
// Step counter with per-second rate tracking, early-burst window statistics
// and a high-activity run detector.
module fitbit_core
    import fitbit_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int STEP_W      = DEF_STEP_W,
    parameter int STEP_SAT    = DEF_STEP_SAT,
    parameter int OVER_RATE   = DEF_OVER_RATE,
    parameter int OVER_SECS   = DEF_OVER_SECS,
    parameter int HI_RATE     = DEF_HI_RATE,
    parameter int HI_MIN      = DEF_HI_MIN
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PULSE,
    input  logic              CLR,
    output logic [STEP_W-1:0] STEPS,
    output logic              SAT,
    output logic [STEP_W-11:0] DIST_HALF,
    output logic [OVER_W-1:0] OVER_CNT,
    output logic [HI_W-1:0]   HI_TIME,
    output logic              SEC_TICK
);

    localparam logic [STEP_W-1:0] SAT_V       = STEP_W'(STEP_SAT);
    localparam logic [RATE_W-1:0] OVER_RATE_L = RATE_W'(OVER_RATE);
    localparam logic [RATE_W-1:0] HI_RATE_L   = RATE_W'(HI_RATE);
    localparam logic [OVER_W-1:0] OVER_SECS_L = OVER_W'(OVER_SECS);
    localparam logic [RUN_W-1:0]  HI_MIN_L    = RUN_W'(HI_MIN);
    localparam logic [HI_W-1:0]   HI_MIN_ADD  = HI_W'(HI_MIN);

    // Edge history is stored as "previous cycle was low" so that its reset
    // value of 0 also blocks a PULSE already high at reset release.
    logic              prev_low;
    logic              step;
    logic [RATE_W-1:0] rate;
    logic [OVER_W-1:0] sec_cnt;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_nxt;
    logic              qual;
    hi_state_t         hi_state;

    assign step      = PULSE & prev_low;
    assign SAT       = (STEPS == SAT_V);
    assign DIST_HALF = STEPS[STEP_W-1:10];
    assign qual      = (rate >= HI_RATE_L);
    assign run_nxt   = run + 1'b1;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (CLR),
        .TICK  (SEC_TICK)
    );

    // Edge history: remember whether PULSE was low last cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)   prev_low <= 1'b0;
        else if (CLR) prev_low <= 1'b0;
        else          prev_low <= ~PULSE;
    end

    // Total step count, saturating
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                      STEPS <= '0;
        else if (CLR)                    STEPS <= '0;
        else if (step && STEPS != SAT_V) STEPS <= STEPS + 1'b1;
    end

    // Steps in the current second; a step on the tick cycle opens the new second
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                              rate <= '0;
        else if (CLR)                            rate <= '0;
        else if (SEC_TICK)                       rate <= {{(RATE_W-1){1'b0}}, step};
        else if (step && rate != {RATE_W{1'b1}}) rate <= rate + 1'b1;
    end

    // Early-burst window: count fast seconds among the first OVER_SECS
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sec_cnt  <= '0;
            OVER_CNT <= '0;
        end else if (CLR) begin
            sec_cnt  <= '0;
            OVER_CNT <= '0;
        end else if (SEC_TICK && sec_cnt < OVER_SECS_L) begin
            sec_cnt <= sec_cnt + 1'b1;
            if (rate > OVER_RATE_L) OVER_CNT <= OVER_CNT + 1'b1;
        end
    end

    // High-activity FSM: credit a run only once it lasts HI_MIN seconds
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hi_state <= ST_IDLE;
            run      <= '0;
            HI_TIME  <= '0;
        end else if (CLR) begin
            hi_state <= ST_IDLE;
            run      <= '0;
            HI_TIME  <= '0;
        end else if (SEC_TICK) begin
            case (hi_state)
                ST_IDLE: begin
                    if (qual) begin
                        run      <= {{(RUN_W-1){1'b0}}, 1'b1};
                        hi_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (qual) begin
                        run <= run_nxt;
                        if (run_nxt == HI_MIN_L) begin
                            HI_TIME  <= sat_add_hi(HI_TIME, HI_MIN_ADD);
                            hi_state <= ST_ACTIVE;
                        end
                    end else begin
                        run      <= '0;
                        hi_state <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (qual) begin
                        HI_TIME <= sat_add_hi(HI_TIME, {{(HI_W-1){1'b0}}, 1'b1});
                    end else begin
                        run      <= '0;
                        hi_state <= ST_IDLE;
                    end
                end
                default: begin
                    run      <= '0;
                    hi_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fitbit_core.sv
// Directed bench for fitbit_core with a short second so full scenarios fit.
module tb_fitbit_core;
    import fitbit_pkg::*;

    localparam int T      = 250;
    localparam int STEP_W = 14;

    logic              CLK   = 1'b0;
    logic              RST_N = 1'b0;
    logic              PULSE = 1'b0;
    logic              CLR   = 1'b0;
    logic [STEP_W-1:0] STEPS;
    logic              SAT;
    logic [STEP_W-11:0] DIST_HALF;
    logic [3:0]        OVER_CNT;
    logic [15:0]       HI_TIME;
    logic              SEC_TICK;

    int n_run  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    fitbit_core #(
        .TICK_CYCLES (T),
        .STEP_W      (STEP_W),
        .STEP_SAT    (9999),
        .OVER_RATE   (32),
        .OVER_SECS   (9),
        .HI_RATE     (64),
        .HI_MIN      (60)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .PULSE     (PULSE),
        .CLR       (CLR),
        .STEPS     (STEPS),
        .SAT       (SAT),
        .DIST_HALF (DIST_HALF),
        .OVER_CNT  (OVER_CNT),
        .HI_TIME   (HI_TIME),
        .SEC_TICK  (SEC_TICK)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            PULSE = 1'b0;
            @(negedge CLK);
        end
    endtask

    // Leaves us at the negedge right after the clearing edge
    task automatic do_clr();
        @(negedge CLK);
        CLR   = 1'b1;
        PULSE = 1'b0;
        @(negedge CLK);
        CLR   = 1'b0;
    endtask

    // One aligned second of n steps; optionally check HI_TIME of the previous second
    task automatic run_sec(input int n, input bit en, input string tag, input int want);
        for (int i = 0; i < T; i++) begin
            if (en && i == 2) chk(tag, 32'(HI_TIME), 32'(want));
            PULSE = (i % 2 == 1) && (i / 2 < n);
            @(negedge CLK);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_steps", 32'(STEPS), 0);
        chk("rst_sat", 32'(SAT), 0);
        chk("rst_dist", 32'(DIST_HALF), 0);
        chk("rst_over", 32'(OVER_CNT), 0);
        chk("rst_hi", 32'(HI_TIME), 0);
        chk("rst_tick", 32'(SEC_TICK), 0);
        RST_N = 1'b1;

        // Early-burst window: 33/s counts, 32/s does not
        do_clr();
        for (int s = 0; s < 12; s++) run_sec(33, 1'b0, "", 0);
        idle(2);
        chk("over33_cnt", 32'(OVER_CNT), 9);
        chk("over33_steps", 32'(STEPS), 396);
        do_clr();
        for (int s = 0; s < 12; s++) run_sec(32, 1'b0, "", 0);
        idle(2);
        chk("over32_cnt", 32'(OVER_CNT), 0);
        chk("over32_steps", 32'(STEPS), 384);

        // High activity
        do_clr();
        for (int s = 0; s < 59; s++) run_sec(64, 1'b0, "", 0);
        run_sec(64, 1'b1, "hi_59s", 0);
        run_sec(64, 1'b1, "hi_60s", 60);
        run_sec(63, 1'b1, "hi_61s", 61);
        run_sec(64, 1'b1, "hi_after63", 61);
        for (int s = 0; s < 9; s++) run_sec(64, 1'b0, "", 0);
        idle(2);
        chk("hi_final", 32'(HI_TIME), 61);
        chk("hi_state_run", 32'(dut.hi_state), 32'(ST_RUN));
        chk("hi_run_len", 32'(dut.run), 10);
        chk("hi_steps", 32'(STEPS), 4607);
        chk("hi_dist", 32'(DIST_HALF), 4);
        chk("hi_over", 32'(OVER_CNT), 9);

        // Tick timing and edge/tick collision
        do_clr();
        idle(T - 1);
        chk("tick_early", 32'(SEC_TICK), 0);
        idle(1);
        chk("tick_first", 32'(SEC_TICK), 1);
        PULSE = 1'b1;
        @(negedge CLK);
        for (int j = 0; j < T - 1; j++) begin
            PULSE = (j % 2 == 1) && (j / 2 < 32);
            @(negedge CLK);
        end
        idle(2);
        chk("coll_over", 32'(OVER_CNT), 1);
        chk("coll_steps", 32'(STEPS), 33);
        PULSE = 1'b1;
        repeat (50) @(negedge CLK);
        idle(2);
        chk("held_steps", 32'(STEPS), 34);

        // CLR mid-run, coincident with a step and a tick
        do_clr();
        for (int s = 0; s < 30; s++) run_sec(64, 1'b0, "", 0);
        chk("mid_steps", 32'(STEPS), 1920);
        chk("mid_run", 32'(dut.run), 29);
        chk("mid_tick", 32'(SEC_TICK), 1);
        CLR   = 1'b1;
        PULSE = 1'b1;
        @(negedge CLK);
        chk("clr_steps", 32'(STEPS), 0);
        chk("clr_over", 32'(OVER_CNT), 0);
        chk("clr_hi", 32'(HI_TIME), 0);
        chk("clr_tick", 32'(SEC_TICK), 0);
        chk("clr_state", 32'(dut.hi_state), 32'(ST_IDLE));
        chk("clr_run", 32'(dut.run), 0);
        chk("clr_rate", 32'(dut.rate), 0);
        CLR = 1'b0;
        idle(T - 1);
        chk("clr_tick_early", 32'(SEC_TICK), 0);
        idle(1);
        chk("clr_tick_first", 32'(SEC_TICK), 1);
        chk("clr_steps_after", 32'(STEPS), 0);

        // Saturation
        do_clr();
        idle(1);
        for (int k = 1; k <= 10005; k++) begin
            PULSE = 1'b1;
            @(negedge CLK);
            PULSE = 1'b0;
            @(negedge CLK);
            if (k == 1024) chk("sat_dist1", 32'(DIST_HALF), 1);
            if (k == 9998) begin
                chk("sat_9998", 32'(STEPS), 9998);
                chk("sat_flag_lo", 32'(SAT), 0);
            end
            if (k == 9999) begin
                chk("sat_9999", 32'(STEPS), 9999);
                chk("sat_flag_hi", 32'(SAT), 1);
            end
        end
        chk("sat_steps", 32'(STEPS), 9999);
        chk("sat_flag", 32'(SAT), 1);
        chk("sat_dist", 32'(DIST_HALF), 9);

        // Asynchronous reset between edges, PULSE high at release
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_steps", 32'(STEPS), 0);
        chk("arst_sat", 32'(SAT), 0);
        chk("arst_dist", 32'(DIST_HALF), 0);
        chk("arst_over", 32'(OVER_CNT), 0);
        chk("arst_hi", 32'(HI_TIME), 0);
        chk("arst_state", 32'(dut.hi_state), 32'(ST_IDLE));
        PULSE = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        chk("rel_no_step", 32'(STEPS), 0);
        idle(1);
        PULSE = 1'b1;
        @(negedge CLK);
        PULSE = 1'b0;
        @(negedge CLK);
        chk("rel_one_step", 32'(STEPS), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
